// File: rtl/cpu_top_system.sv
// Board-level teaching CPU: 8-bit single-cycle accumulator machine with program ROM,
// 16x8 register file, switch input and a scanned 8-digit seven-segment display.
module cpu_top_system #(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk_100,
    input  logic       rst_n,
    input  logic       finish,
    input  logic [7:0] switch_in,
    output logic [7:0] switch,
    output logic [7:0] test_pc,
    output logic [7:0] tube_scan,
    output logic [7:0] tube_signal_left,
    output logic [7:0] tube_signal_right
);
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [7:0] pc_reg, pc_next;
    logic [7:0] acc_reg, acc_next;
    logic [7:0] out_reg;
    logic       halt_reg;
    logic [7:0] switch_reg;
    logic [7:0] rf_reg [16];
    logic [7:0] instr;
    logic [3:0] op, k;
    logic       run, rf_we, out_we;
    logic [CNT_W-1:0] scan_cnt_reg;
    logic [2:0] scan_idx_reg;
    logic [3:0] nibble;
    logic [7:0] seg;

    function automatic logic [7:0] rom(input logic [7:0] a);
        case (a)
            8'd0:  rom = 8'h20;  8'd1:  rom = 8'h31;  8'd2:  rom = 8'h10;
            8'd3:  rom = 8'h32;  8'd4:  rom = 8'h11;  8'd5:  rom = 8'h33;
            8'd6:  rom = 8'h41;  8'd7:  rom = 8'h7E;  8'd8:  rom = 8'h52;
            8'd9:  rom = 8'h32;  8'd10: rom = 8'h41;  8'd11: rom = 8'h63;
            8'd12: rom = 8'h31;  8'd13: rom = 8'h86;  8'd14: rom = 8'h42;
            8'd15: rom = 8'h90;  default: rom = 8'hF0;
        endcase
    endfunction

    function automatic logic [7:0] seg_code(input logic [3:0] h);
        case (h)
            4'h0: seg_code = 8'h3F;  4'h1: seg_code = 8'h06;  4'h2: seg_code = 8'h5B;
            4'h3: seg_code = 8'h4F;  4'h4: seg_code = 8'h66;  4'h5: seg_code = 8'h6D;
            4'h6: seg_code = 8'h7D;  4'h7: seg_code = 8'h07;  4'h8: seg_code = 8'h7F;
            4'h9: seg_code = 8'h6F;  4'hA: seg_code = 8'h77;  4'hB: seg_code = 8'h7C;
            4'hC: seg_code = 8'h39;  4'hD: seg_code = 8'h5E;  4'hE: seg_code = 8'h79;
            default: seg_code = 8'h71;
        endcase
    endfunction

    assign instr = rom(pc_reg);
    assign op    = instr[7:4];
    assign k     = instr[3:0];
    assign run   = !finish && !halt_reg;

    always_comb begin
        pc_next  = pc_reg + 8'd1;
        acc_next = acc_reg;
        rf_we    = 1'b0;
        out_we   = 1'b0;
        case (op)
            4'h1: acc_next = {4'h0, k};
            4'h2: acc_next = switch_in;
            4'h3: rf_we    = 1'b1;
            4'h4: acc_next = rf_reg[k];
            4'h5: acc_next = acc_reg + rf_reg[k];
            4'h6: acc_next = acc_reg - rf_reg[k];
            4'h7: if (acc_reg == 8'h00) pc_next = {pc_reg[7:4], k};
            4'h8: pc_next  = {pc_reg[7:4], k};
            4'h9: out_we   = 1'b1;
            4'hF: pc_next  = pc_reg;
            default: ;
        endcase
    end

    always_ff @(posedge clk_100 or posedge rst_n) begin
        if (rst_n) begin
            pc_reg     <= 8'h00;
            acc_reg    <= 8'h00;
            out_reg    <= 8'h00;
            halt_reg   <= 1'b0;
            switch_reg <= 8'h00;
        end else begin
            switch_reg <= switch_in;
            if (run) begin
                pc_reg  <= pc_next;
                acc_reg <= acc_next;
                if (out_we) out_reg <= acc_reg;
                if (op == 4'hF) halt_reg <= 1'b1;
            end
        end
    end

    // Register file needs a full clear on reset, so each entry is its own flop bank.
    for (genvar gi = 0; gi < 16; gi++) begin : g_rf
        always_ff @(posedge clk_100 or posedge rst_n) begin
            if (rst_n)
                rf_reg[gi] <= 8'h00;
            else if (run && rf_we && k == 4'(gi))
                rf_reg[gi] <= acc_reg;
        end
    end

    always_ff @(posedge clk_100 or posedge rst_n) begin
        if (rst_n) begin
            scan_cnt_reg <= '0;
            scan_idx_reg <= 3'd0;
        end else if (scan_cnt_reg == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt_reg <= '0;
            scan_idx_reg <= scan_idx_reg + 3'd1;
        end else begin
            scan_cnt_reg <= scan_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        case (scan_idx_reg)
            3'd7:    nibble = switch_reg[7:4];
            3'd6:    nibble = switch_reg[3:0];
            3'd5:    nibble = pc_reg[7:4];
            3'd4:    nibble = pc_reg[3:0];
            3'd3:    nibble = acc_reg[7:4];
            3'd2:    nibble = acc_reg[3:0];
            3'd1:    nibble = out_reg[7:4];
            default: nibble = out_reg[3:0];
        endcase
    end

    assign seg               = seg_code(nibble);
    assign tube_scan         = ~(8'd1 << scan_idx_reg);
    assign tube_signal_left  = scan_idx_reg[2] ? seg : 8'h00;
    assign tube_signal_right = scan_idx_reg[2] ? 8'h00 : seg;
    assign switch            = switch_reg;
    assign test_pc           = pc_reg;
endmodule

// File: tb/tb_cpu_top_system.sv
// Directed bench for cpu_top_system: program results, cycle counts, stall,
// asynchronous mid-run reset and the display scan sequence.
module tb_cpu_top_system;
    logic       clk_100;
    logic       rst_n;
    logic       finish;
    logic [7:0] switch_in;
    logic [7:0] switch, test_pc, tube_scan, tube_signal_left, tube_signal_right;

    int total = 0;
    int bad   = 0;

    logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    cpu_top_system #(.SCAN_DIV(4)) dut (
        .clk_100          (clk_100),
        .rst_n            (rst_n),
        .finish           (finish),
        .switch_in        (switch_in),
        .switch           (switch),
        .test_pc          (test_pc),
        .tube_scan        (tube_scan),
        .tube_signal_left (tube_signal_left),
        .tube_signal_right(tube_signal_right)
    );

    initial begin
        clk_100 = 1'b0;
        forever #5 clk_100 = ~clk_100;
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%02h expected=%02h", tag, got, exp);
        end else begin
            $display("ok   %s: %02h", tag, got);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        @(negedge clk_100);
        @(negedge clk_100);
        rst_n = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_100);
        #1;
    endtask

    // Wait (bounded) for digit d to be selected and return its segment bus.
    task automatic read_digit(input int d, output logic [7:0] seg);
        logic [7:0] want;
        int n;
        want = ~(8'd1 << d);
        n = 0;
        @(negedge clk_100);
        while (tube_scan !== want && n < 64) begin
            @(negedge clk_100);
            n++;
        end
        chk($sformatf("scan_sel_d%0d", d), tube_scan, want);
        seg = (d >= 4) ? tube_signal_left : tube_signal_right;
    endtask

    task automatic check_digit(input int d, input logic [3:0] hex);
        logic [7:0] s;
        read_digit(d, s);
        chk($sformatf("digit%0d", d), s, seg_tab[hex]);
    endtask

    initial begin
        rst_n = 1'b1;
        finish = 1'b0;
        switch_in = 8'h00;
        #2;
        chk("rst_pc", test_pc, 8'h00);
        chk("rst_scan", tube_scan, 8'hFE);
        chk("rst_switch", switch, 8'h00);
        chk("rst_right", tube_signal_right, 8'h3F);
        chk("rst_left", tube_signal_left, 8'h00);

        // N=7: sum is 0x1C, OUT lands on cycle 66
        switch_in = 8'h07;
        do_reset();
        cycles(65);
        chk("n7_pc_c65", test_pc, 8'h0F);
        cycles(1);
        chk("n7_pc_c66", test_pc, 8'h10);
        cycles(5);
        chk("n7_pc_hold", test_pc, 8'h10);
        chk("n7_switch", switch, 8'h07);
        check_digit(0, 4'hC);
        check_digit(1, 4'h1);
        check_digit(2, 4'hC);
        check_digit(3, 4'h1);
        check_digit(4, 4'h0);
        check_digit(5, 4'h1);
        check_digit(6, 4'h7);
        check_digit(7, 4'h0);

        // N=0: halts after 10 cycles with OUT=ACC=0
        switch_in = 8'h00;
        do_reset();
        cycles(9);
        chk("n0_pc_c9", test_pc, 8'h0F);
        cycles(1);
        chk("n0_pc_c10", test_pc, 8'h10);
        check_digit(0, 4'h0);
        check_digit(1, 4'h0);
        check_digit(2, 4'h0);
        check_digit(3, 4'h0);

        // Stall cycles 20..29: PC after 19 instructions is 0x0B
        switch_in = 8'h07;
        do_reset();
        cycles(19);
        chk("stall_pc_before", test_pc, 8'h0B);
        finish = 1'b1;
        cycles(10);
        chk("stall_pc_frozen", test_pc, 8'h0B);
        finish = 1'b0;
        cycles(45);
        chk("stall_pc_c74", test_pc, 8'h0E);
        cycles(1);
        chk("stall_pc_c75", test_pc, 8'h0F);
        cycles(1);
        chk("stall_pc_c76", test_pc, 8'h10);
        check_digit(0, 4'hC);
        check_digit(1, 4'h1);

        // Mid-run asynchronous reset at cycle 30, then full rerun
        do_reset();
        cycles(30);
        #1;
        rst_n = 1'b1;
        #1;
        chk("midrst_pc_async", test_pc, 8'h00);
        chk("midrst_scan_async", tube_scan, 8'hFE);
        @(negedge clk_100);
        rst_n = 1'b0;
        cycles(66);
        chk("midrst_pc_c66", test_pc, 8'h10);
        check_digit(0, 4'hC);
        check_digit(1, 4'h1);

        // Scan sequence: each digit held 4 cycles, buses blanked on the other half
        do_reset();
        for (int c = 0; c < 36; c++) begin
            int idx;
            if (c > 0) cycles(1);
            idx = (c / 4) % 8;
            chk($sformatf("scan_c%0d", c), tube_scan, ~(8'd1 << idx));
            if (idx >= 4)
                chk($sformatf("scan_right_blank_c%0d", c), tube_signal_right, 8'h00);
            else
                chk($sformatf("scan_left_blank_c%0d", c), tube_signal_left, 8'h00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
